// File: rtl/spgd_perturb_seq_if.sv
// Actuator-write, metric-handshake and gradient-stream bundle of the SPGD perturbation sequencer.
// master = sequencer side (drives apply/meas_req/upd, receives meas_valid/meas_data);
// slave  = actuator DAC, metric ADC and update-stage side.
interface spgd_perturb_seq_if #(
  parameter int NCH          = 8,
  parameter int RNG_WIDTH    = 12,
  parameter int METRIC_WIDTH = 16
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                           apply_valid;
  logic [IW-1:0]                  apply_idx;
  logic signed [RNG_WIDTH-1:0]    apply_val;
  logic                           meas_req;
  logic                           meas_valid;
  logic [METRIC_WIDTH-1:0]        meas_data;
  logic                           upd_valid;
  logic [IW-1:0]                  upd_idx;
  logic signed [RNG_WIDTH-1:0]    upd_pert;
  logic signed [METRIC_WIDTH:0]   upd_dj;

  modport master (
    output apply_valid, apply_idx, apply_val, meas_req,
    output upd_valid, upd_idx, upd_pert, upd_dj,
    input  meas_valid, meas_data
  );

  modport slave (
    input  apply_valid, apply_idx, apply_val, meas_req,
    input  upd_valid, upd_idx, upd_pert, upd_dj,
    output meas_valid, meas_data
  );
endinterface

// File: rtl/spgd_perturb_seq.sv
// SPGD iteration sequencer: captures u from the dual-output Gaussian RNG, applies +u then -u to the
// actuators, handshakes a metric after each settle period and streams (u, J+ - J-) per channel.
// Ports: clk/rst (async, active high), start (level, run back to back), rng_0/rng_1 (RNG samples),
// bus (apply/meas/upd bundle, master side), busy, iter_cnt (completed iterations), timeout_err.
// Optional: define SPGD_SEQ_TIMEOUT_EN to abort an iteration when the metric never answers.
module spgd_perturb_seq #(
  parameter int NCH          = 8,
  parameter int RNG_WIDTH    = 12,
  parameter int METRIC_WIDTH = 16,
  parameter int SETTLE_CYC   = 16,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [RNG_WIDTH-1:0] rng_0,
  input  logic signed [RNG_WIDTH-1:0] rng_1,
  spgd_perturb_seq_if.master          bus,
  output logic                        busy,
  output logic [15:0]                 iter_cnt,
  output logic                        timeout_err
);
  localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CMAX0 = (NCH > SETTLE_CYC) ? NCH : SETTLE_CYC;
  localparam int CMAX  = (CMAX0 > TIMEOUT_CYC) ? CMAX0 : TIMEOUT_CYC;
  localparam int CW    = $clog2(CMAX + 1);

  typedef enum logic [3:0] {
    IDLE, FILL, APPLY_P, SETTLE_P, MEAS_P, APPLY_M, SETTLE_M, MEAS_M, UPDATE
  } state_t;

  state_t                      state, state_n;
  logic [CW-1:0]               cnt, cnt_n;
  logic signed [RNG_WIDTH-1:0] store   [NCH];
  logic signed [RNG_WIDTH-1:0] store_n [NCH];
  logic [METRIC_WIDTH-1:0]     jp, jp_n, jm, jm_n;
  logic                        done;
  logic [IW-1:0]               pair_lo;
  logic [IW-1:0]               cidx;
`ifdef SPGD_SEQ_TIMEOUT_EN
  logic                        to_set;
`endif

  // Negation of the most negative code has no representation; clamp it to the positive limit.
  function automatic logic signed [RNG_WIDTH-1:0] neg_sat(input logic signed [RNG_WIDTH-1:0] v);
    if (v == {1'b1, {(RNG_WIDTH-1){1'b0}}})
      return {1'b0, {(RNG_WIDTH-1){1'b1}}};
    return -v;
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    store_n = store;
    jp_n    = jp;
    jm_n    = jm;
    done    = 1'b0;
    pair_lo = IW'({cnt, 1'b0});
`ifdef SPGD_SEQ_TIMEOUT_EN
    to_set  = 1'b0;
`endif
    case (state)
      IDLE: if (start) begin
        state_n = FILL;
        cnt_n   = '0;
      end
      FILL: begin
        store_n[pair_lo]         = rng_0;
        store_n[pair_lo | IW'(1)] = rng_1;
        if (cnt == CW'(NCH/2 - 1)) begin state_n = APPLY_P; cnt_n = '0; end
        else cnt_n = cnt + CW'(1);
      end
      APPLY_P, APPLY_M: begin
        if (cnt == CW'(NCH - 1)) begin
          state_n = (state == APPLY_P) ? SETTLE_P : SETTLE_M;
          cnt_n   = '0;
        end else cnt_n = cnt + CW'(1);
      end
      SETTLE_P, SETTLE_M: begin
        if (cnt == CW'(SETTLE_CYC - 1)) begin
          state_n = (state == SETTLE_P) ? MEAS_P : MEAS_M;
          cnt_n   = '0;
        end else cnt_n = cnt + CW'(1);
      end
      MEAS_P, MEAS_M: begin
        if (bus.meas_valid) begin
          if (state == MEAS_P) begin jp_n = bus.meas_data; state_n = APPLY_M; end
          else                 begin jm_n = bus.meas_data; state_n = UPDATE;  end
          cnt_n = '0;
        end
`ifdef SPGD_SEQ_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          to_set  = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else cnt_n = cnt + CW'(1);
`endif
      end
      UPDATE: begin
        if (cnt == CW'(NCH - 1)) begin
          done    = 1'b1;
          state_n = start ? FILL : IDLE;
          cnt_n   = '0;
        end else cnt_n = cnt + CW'(1);
      end
      default: state_n = IDLE;
    endcase
    cidx = IW'(cnt_n);
  end

  // Outputs are registered from the next-state values so they line up with the state they describe;
  // store_n is used so the first APPLY_P write sees the pair captured on the final FILL edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      store           <= '{default: '0};
      jp              <= '0;
      jm              <= '0;
      bus.apply_valid <= 1'b0;
      bus.apply_idx   <= '0;
      bus.apply_val   <= '0;
      bus.meas_req    <= 1'b0;
      bus.upd_valid   <= 1'b0;
      bus.upd_idx     <= '0;
      bus.upd_pert    <= '0;
      bus.upd_dj      <= '0;
      busy            <= 1'b0;
      iter_cnt        <= '0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      store           <= store_n;
      jp              <= jp_n;
      jm              <= jm_n;
      bus.apply_valid <= (state_n == APPLY_P) || (state_n == APPLY_M);
      bus.apply_idx   <= ((state_n == APPLY_P) || (state_n == APPLY_M)) ? cidx : '0;
      bus.apply_val   <= (state_n == APPLY_P) ? store_n[cidx] :
                         (state_n == APPLY_M) ? neg_sat(store_n[cidx]) : '0;
      bus.meas_req    <= ((state_n == SETTLE_P) || (state_n == SETTLE_M)) &&
                         (cnt_n == CW'(SETTLE_CYC - 1));
      bus.upd_valid   <= (state_n == UPDATE);
      bus.upd_idx     <= (state_n == UPDATE) ? cidx : '0;
      bus.upd_pert    <= (state_n == UPDATE) ? store_n[cidx] : '0;
      bus.upd_dj      <= (state_n == UPDATE) ? ({1'b0, jp_n} - {1'b0, jm_n}) : '0;
      busy            <= (state_n != IDLE);
      if (done) iter_cnt <= iter_cnt + 16'd1;
    end
  end

`ifdef SPGD_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         timeout_err <= 1'b0;
    else if (to_set) timeout_err <= 1'b1;
  end
`else
  assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_spgd_perturb_seq.sv
module tb_spgd_perturb_seq;
  localparam int NCH = 8;
  localparam int RW  = 12;
  localparam int MW  = 16;
  localparam int S   = 4;
  localparam int TO  = 10;
  localparam int IW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [RW-1:0] rng_0 = '0, rng_1 = '0;
  logic          busy, timeout_err;
  logic [15:0]   iter_cnt;

  int          cyc = 0, n_cmp = 0, n_err = 0;
  logic [15:0] exp_iter = '0;
  logic        exp_to = 1'b0;
  bit          chained = 1'b0;

  spgd_perturb_seq_if #(.NCH(NCH), .RNG_WIDTH(RW), .METRIC_WIDTH(MW)) bus ();

  spgd_perturb_seq #(.NCH(NCH), .RNG_WIDTH(RW), .METRIC_WIDTH(MW), .SETTLE_CYC(S), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .rng_0(rng_0), .rng_1(rng_1), .bus(bus),
    .busy(busy), .iter_cnt(iter_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): observed %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // RNG sample with extra weight on the two extreme codes.
  function automatic logic [RW-1:0] pick();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 12'h800;
    if (r == 1) return 12'h7FF;
    return RW'($urandom);
  endfunction

  // Reference negation: two's-complement value, negated, clamped to the representable range.
  function automatic logic [RW-1:0] neg_ref(input logic [RW-1:0] v);
    int s;
    s = v[RW-1] ? int'(v) - (1 << RW) : int'(v);
    s = -s;
    if (s > (1 << (RW-1)) - 1) s = (1 << (RW-1)) - 1;
    return RW'(s);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    rng_0 = pick();
    rng_1 = pick();
    cyc++;
  endtask

  // Called in the first FILL cycle. Walks the whole iteration, comparing against the expected
  // timeline; ends in the cycle after the last update beat (or after a timeout / reset abort).
  task automatic do_iter(input logic [MW-1:0] jp, input logic [MW-1:0] jm, input int lat_p,
                         input int lat_m, input bit spur, input bit hold, input bit abort);
    logic [RW-1:0] u [NCH];
    logic [MW:0]   dj;
    int            t0;
    t0    = cyc;
    start = hold;
    dj    = (MW+1)'(int'(jp) - int'(jm));
    for (int k = 0; k < NCH/2; k++) begin
      check("fill", {busy, bus.apply_valid, bus.upd_valid}, {1'b1, 1'b0, 1'b0});
      u[2*k] = rng_0;
      u[2*k+1] = rng_1;
      next_cycle();
    end
    for (int i = 0; i < NCH; i++) begin
      check("apply_p", {bus.apply_valid, bus.apply_idx, bus.apply_val}, {1'b1, IW'(i), u[i]});
      next_cycle();
    end
    for (int i = 0; i < S; i++) begin
      check("settle_p", {bus.apply_valid, bus.meas_req}, {1'b0, (i == S-1)});
      bus.meas_valid = spur && (i == 0 || i == S-1);
      bus.meas_data  = MW'($urandom);
      next_cycle();
    end
`ifdef SPGD_SEQ_TIMEOUT_EN
    if (lat_p >= TO) begin
      for (int i = 0; i < TO; i++) begin
        check("meas_wait", {busy, timeout_err}, {1'b1, exp_to});
        bus.meas_valid = 1'b0;
        next_cycle();
      end
      check("timeout", {busy, timeout_err, bus.upd_valid, iter_cnt}, {1'b0, 1'b1, 1'b0, exp_iter});
      exp_to = 1'b1;
      return;
    end
`endif
    for (int i = 0; i <= lat_p; i++) begin
      check("meas_p", {busy, bus.apply_valid, bus.meas_req}, {1'b1, 1'b0, 1'b0});
      bus.meas_valid = (i == lat_p);
      bus.meas_data  = (i == lat_p) ? jp : MW'($urandom);
      next_cycle();
    end
    bus.meas_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      check("apply_m", {bus.apply_valid, bus.apply_idx, bus.apply_val}, {1'b1, IW'(i), neg_ref(u[i])});
      next_cycle();
    end
    for (int i = 0; i < S; i++) begin
      check("settle_m", {bus.apply_valid, bus.meas_req}, {1'b0, (i == S-1)});
      if (abort && i == 1) begin
        rst = 1'b1;
        #1;
        check("rst_out_a", {bus.apply_valid, bus.apply_idx, bus.apply_val, bus.meas_req,
                            bus.upd_valid, bus.upd_idx, bus.upd_pert}, 64'd0);
        check("rst_out_b", {bus.upd_dj, busy, timeout_err, iter_cnt}, 64'd0);
        exp_iter = '0;
        exp_to   = 1'b0;
        for (int j = 0; j < 3; j++) begin
          next_cycle();
          check("rst_hold", {busy, bus.upd_valid, bus.apply_valid}, 64'd0);
        end
        rst = 1'b0;
        next_cycle();
        check("rst_idle", {busy, bus.upd_valid}, 64'd0);
        return;
      end
      bus.meas_valid = spur && (i == 0 || i == S-1);
      bus.meas_data  = MW'($urandom);
      next_cycle();
    end
    for (int i = 0; i <= lat_m; i++) begin
      check("meas_m", {busy, bus.apply_valid, bus.meas_req}, {1'b1, 1'b0, 1'b0});
      bus.meas_valid = (i == lat_m);
      bus.meas_data  = (i == lat_m) ? jm : MW'($urandom);
      next_cycle();
    end
    bus.meas_valid = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      check("update", {bus.upd_valid, bus.upd_idx, bus.upd_pert, bus.upd_dj}, {1'b1, IW'(i), u[i], dj});
      next_cycle();
    end
    exp_iter = exp_iter + 16'd1;
    check("post", {busy, bus.upd_valid, bus.apply_valid, iter_cnt}, {hold, 1'b0, 1'b0, exp_iter});
    check("post_to", timeout_err, exp_to);
    check("cycles", cyc - t0, NCH/2 + 3*NCH + 2*S + 2 + lat_p + lat_m);
  endtask

  task automatic run_iter(input logic [MW-1:0] jp, input logic [MW-1:0] jm, input int lat_p,
                          input int lat_m, input bit spur, input bit hold, input bit abort);
    if (!chained) begin
      start = 1'b1;
      next_cycle();
    end
    do_iter(jp, jm, lat_p, lat_m, spur, hold, abort);
    chained = hold && !abort;
  endtask

  initial begin
    bus.meas_valid = 1'b0;
    bus.meas_data  = '0;
    repeat (3) next_cycle();
    check("reset_a", {bus.apply_valid, bus.apply_idx, bus.apply_val, bus.meas_req,
                      bus.upd_valid, bus.upd_idx, bus.upd_pert}, 64'd0);
    check("reset_b", {bus.upd_dj, busy, timeout_err, iter_cnt}, 64'd0);
    rst = 1'b0;
    next_cycle();
    next_cycle();
    check("idle", {busy, bus.apply_valid}, 64'd0);

    run_iter(16'h1234, 16'h1000, 0, 0, 1'b0, 1'b0, 1'b0);
    run_iter(16'h0000, 16'hFFFF, 1, 2, 1'b0, 1'b0, 1'b0);
    run_iter(16'hFFFF, 16'h0000, 0, 3, 1'b0, 1'b0, 1'b0);
    run_iter(16'h4000, 16'h3000, 0, 0, 1'b0, 1'b1, 1'b0);
    run_iter(16'h0100, 16'h0200, 0, 0, 1'b0, 1'b1, 1'b0);
    run_iter(16'h8000, 16'h7FFF, 0, 0, 1'b0, 1'b0, 1'b0);
    run_iter(16'h1111, 16'h2222, 0, 0, 1'b0, 1'b0, 1'b1);
    run_iter(16'h5555, 16'h1111, 2, 1, 1'b0, 1'b0, 1'b0);
    run_iter(16'hABCD, 16'h1234, 0, 0, 1'b1, 1'b0, 1'b0);
    run_iter(16'h0042, 16'h0041, 3, 0, 1'b1, 1'b1, 1'b0);

    for (int n = 0; n < 16; n++)
      run_iter(MW'($urandom), MW'($urandom), $urandom_range(0, 6), $urandom_range(0, 6),
               1'($urandom), (n < 15) ? 1'($urandom) : 1'b0, 1'b0);

`ifdef SPGD_SEQ_TIMEOUT_EN
    run_iter(16'h1000, 16'h0800, TO, 0, 1'b0, 1'b0, 1'b0);
    chained = 1'b0;
    run_iter(16'h0900, 16'h0100, 1, 1, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spgd_perturb_seq.md
# spgd_perturb_seq

Sequencer for one SPGD iteration built around the dual-output Gaussian RNG (`TOP_RNG`). It captures a perturbation vector from the RNG's two outputs and applies it to the actuator channels as +u and then −u. After each polarity it waits a settle time and handshakes a metric measurement. It then streams the per-channel gradient terms (u, J+ − J−) to the update stage. It sits between `TOP_RNG`, the actuator (DAC) write port and the metric ADC front end.

## Interface
- `NCH`, 8, actuator channel count; must be even and ≥ 2.
- `RNG_WIDTH`, 12, width of each RNG output, two's complement.
- `METRIC_WIDTH`, 16, unsigned metric width.
- `SETTLE_CYC`, 16, cycles waited after the last actuator write before a measurement request; must be ≥ 1.
- `TIMEOUT_CYC`, 255, measurement wait limit (used only with the timeout feature).

Ports:
- `clk`, in, 1, single clock.
- `rst`, in, 1, asynchronous active-high reset.
- `start`, in, 1, level; high = run iterations back to back.
- `rng_0`, `rng_1`, in, RNG_WIDTH each, `TOP_RNG` `out_0`/`out_1`; a new sample is presented every cycle.
- `apply_valid`, out, 1, actuator write strobe.
- `apply_idx`, out, clog2(NCH), channel index.
- `apply_val`, out, RNG_WIDTH, signed value: +u or −u.
- `meas_req`, out, 1, one-cycle measurement request pulse.
- `meas_valid`, in, 1, metric valid.
- `meas_data`, in, METRIC_WIDTH, metric value.
- `upd_valid`, out, 1, gradient term strobe.
- `upd_idx`, out, clog2(NCH), channel index.
- `upd_pert`, out, RNG_WIDTH, u for that channel.
- `upd_dj`, out, METRIC_WIDTH+1, signed J+ − J−.
- `busy`, out, 1, high in every state except IDLE.
- `iter_cnt`, out, 16, completed iterations; wraps from 0xFFFF to 0.
- `timeout_err`, out, 1, sticky measurement-timeout flag.

## Operation
State sequence: IDLE → FILL → APPLY_P → SETTLE_P → MEAS_P → APPLY_M → SETTLE_M → MEAS_M → UPDATE.
- **IDLE**: leave when `start` = 1.
- **FILL**: NCH/2 cycles. Cycle k stores `rng_0` into channel 2k and `rng_1` into channel 2k+1.
- **APPLY_P / APPLY_M**: NCH cycles. `apply_valid` = 1 and `apply_idx` runs 0..NCH−1.
  - `apply_val` = u in APPLY_P.
  - `apply_val` = −u in APPLY_M. The most negative code (−2^(RNG_WIDTH−1)) saturates to +2^(RNG_WIDTH−1)−1 in this phase.
- **SETTLE_x**: exactly SETTLE_CYC cycles. `meas_req` pulses on the last cycle.
- **MEAS_x**: wait for `meas_valid`.
  - MEAS_P latches `meas_data` into J+.
  - MEAS_M latches `meas_data` into J−.
  - A `meas_valid` in any other state is ignored.
- **UPDATE**: NCH cycles. `upd_valid` = 1, `upd_idx` = 0..NCH−1, `upd_pert` = stored u, `upd_dj` = zero-extended J+ − zero-extended J−.
  - The subtraction is exact at METRIC_WIDTH+1 bits; no overflow is possible.
  - `iter_cnt` increments on the last UPDATE cycle.
  - Next state: FILL if `start` = 1, else IDLE.
- `start` deasserting mid-iteration does not abort. The current iteration completes first.
- The perturbation store is overwritten only in FILL.

## Timing
- Reset values: all outputs are 0, the state is IDLE, the store is cleared, J± = 0, `timeout_err` = 0.
- Asserting `rst` mid-iteration returns to IDLE immediately, with no partial update stream.
- All outputs are registered.
- `start` sampled high in IDLE at edge t → FILL begins at t+1 → first `apply_valid` at t+1+NCH/2.
- `meas_req` occurs SETTLE_CYC cycles after the cycle holding the last `apply_valid`.
- `meas_valid` seen at edge t in MEAS_P → first APPLY_M write at t+1.
- `meas_valid` arriving on the same cycle as `meas_req` is not accepted: acceptance starts in MEAS_x.
- Cycles per iteration with zero-latency metric = NCH/2 + 3·NCH + 2·SETTLE_CYC + 2.
- `busy` falls on the cycle after the last `upd_valid` when `start` = 0.

## Configuration
- `SPGD_SEQ_TIMEOUT_EN` defined:
  - A counter runs in each MEAS_x state.
  - If TIMEOUT_CYC cycles pass without `meas_valid`, `timeout_err` is set (sticky until `rst`).
  - The state returns to IDLE without an update stream, and `iter_cnt` does not change.
- `SPGD_SEQ_TIMEOUT_EN` undefined: MEAS_x waits indefinitely, and `timeout_err` is tied to 0.

## Test plan
- **Single iteration**: NCH = 8, SETTLE_CYC = 4, `rng_0`/`rng_1` = channel-indexed constants, J+ = 0x1234, J− = 0x1000, `start` pulsed once.
  - Expect 8 writes of u, then 8 writes of −u.
  - Expect 8 `upd_valid` with `upd_dj` = +0x234.
  - Expect `iter_cnt` = 1 and `busy` low afterwards.
- **Saturation and extremes**:
  - u = 0x800 → APPLY_M writes 0x7FF.
  - J+ = 0, J− = 0xFFFF → `upd_dj` = −65535 (17'h10001).
- **Continuous run**: `start` held high for 3 iterations.
  - FILL follows UPDATE with no IDLE cycle.
  - Cycle count matches the formula above.
  - `iter_cnt` = 3.
- **Asynchronous reset**: `rst` asserted during SETTLE_M.
  - Outputs are 0 immediately, with no `upd_valid`.
  - A restart runs a clean iteration.
- **Spurious and early measurements**: `meas_valid` in SETTLE_P and on the `meas_req` cycle is ignored; a later `meas_valid` is latched.
- **Timeout** (with `SPGD_SEQ_TIMEOUT_EN`, TIMEOUT_CYC = 10): `meas_valid` never asserted.
  - `timeout_err` = 1 after 10 cycles in MEAS_P.
  - The state returns to IDLE.
  - `iter_cnt` is unchanged.
